// File: rtl/cmd_rx_if.sv
// Command handshake from cmd_rx to its consumer: one held opcode/operand set with valid/ready.
interface cmd_rx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] opcode;
    logic [7:0] a;
    logic [7:0] b;

    modport master (output cmd_valid, output opcode, output a, output b, input cmd_ready);
    modport slave  (input cmd_valid, input opcode, input a, input b, output cmd_ready);
endinterface

// File: rtl/cmd_rx.sv
// UART 8N1 receiver feeding a three-byte {opcode, a, b} frame assembler with a held
// valid/ready command output, inter-byte timeout, framing-error and overrun pulses.
module cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     rx,
    cmd_rx_if.master cmd,
    output logic     frame_err,
    output logic     overrun
);
    localparam int unsigned CntW          = $clog2(CLKS_PER_BIT);
    localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned IdleW         = $clog2(TimeoutCycles + 1);

    localparam logic [CntW-1:0]  HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0]  BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;
    typedef enum logic [1:0] {StWaitOp, StWaitA, StWaitB} asm_state_e;

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CntW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;

    asm_state_e       asm_state_q, asm_state_d;
    logic [2:0]       op_buf_q, op_buf_d;
    logic [7:0]       a_buf_q, a_buf_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    logic             cmd_valid_q, cmd_valid_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             byte_done;
    logic             stop_ok;
    logic             gap_idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= StIdle;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            asm_state_q <= StWaitOp;
            op_buf_q    <= '0;
            a_buf_q     <= '0;
            idle_cnt_q  <= '0;
            cmd_valid_q <= 1'b0;
            opcode_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            asm_state_q <= asm_state_d;
            op_buf_q    <= op_buf_d;
            a_buf_q     <= a_buf_d;
            idle_cnt_q  <= idle_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Bit receiver next state: the counter restarts at every sample point.
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        unique case (rx_state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = StStart;
            end
            StStart: begin
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) rx_state_d = StStop;
                end
            end
            StStop: begin
                if (byte_done) begin
                    clk_cnt_d  = '0;
                    rx_state_d = StIdle;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_done = (rx_state_q == StStop) && (clk_cnt_q == BitLast);
        stop_ok   = rx_sync_q;
        gap_idle  = (rx_state_q == StIdle) && (asm_state_q != StWaitOp);
    end

    // Frame assembler and command register next state.
    always_comb begin
        asm_state_d = asm_state_q;
        op_buf_d    = op_buf_q;
        a_buf_d     = a_buf_q;
        idle_cnt_d  = gap_idle ? idle_cnt_q + 1'b1 : '0;
        cmd_valid_d = cmd_valid_q && !cmd.cmd_ready;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (byte_done) begin
            if (!stop_ok) begin
                frame_err_d = 1'b1;
                asm_state_d = StWaitOp;
            end else begin
                unique case (asm_state_q)
                    StWaitOp: begin
                        if (shift_q[7:3] != 5'd0) begin
                            frame_err_d = 1'b1;
                        end else begin
                            op_buf_d    = shift_q[2:0];
                            asm_state_d = StWaitA;
                        end
                    end
                    StWaitA: begin
                        a_buf_d     = shift_q;
                        asm_state_d = StWaitB;
                    end
                    StWaitB: begin
                        asm_state_d = StWaitOp;
                        if (!cmd_valid_q || cmd.cmd_ready) begin
                            cmd_valid_d = 1'b1;
                            opcode_d    = op_buf_q;
                            a_d         = a_buf_q;
                            b_d         = shift_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                    default: asm_state_d = StWaitOp;
                endcase
            end
        end else if (gap_idle && idle_cnt_q == IdleLast) begin
            frame_err_d = 1'b1;
            asm_state_d = StWaitOp;
            idle_cnt_d  = '0;
        end
    end

    always_comb begin
        cmd.cmd_valid = cmd_valid_q;
        cmd.opcode    = opcode_q;
        cmd.a         = a_q;
        cmd.b         = b_q;
        frame_err     = frame_err_q;
        overrun       = overrun_q;
    end
endmodule

// File: tb/tb_cmd_rx.sv
// Randomized and directed bench for cmd_rx: a frame-level reference model feeds a scoreboard
// queue that a separate monitor drains on every accepted command.
module tb_cmd_rx;
    localparam int unsigned Cpb    = 16;
    localparam int unsigned ToBits = 32;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic frame_err, overrun;

    cmd_rx_if cmd ();

    cmd_rx #(
        .CLKS_PER_BIT(Cpb),
        .TIMEOUT_BITS(ToBits)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .cmd      (cmd),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    cmd_t        exp_q[$];
    logic [7:0]  part[$];
    int unsigned exp_ferr = 0, exp_ovr = 0, seen_ferr = 0, seen_ovr = 0;
    bit          hold_mode = 0, held = 0, rand_ready = 1;
    int unsigned last_start = 0;
    int          exp_to_at = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, exp);
    endtask

    // Reference model: frames are runs of three good bytes starting with a value below 8.
    function automatic void model_byte(input logic [7:0] v, input bit stop_good);
        cmd_t c;
        if (!stop_good) begin
            exp_ferr++;
            part.delete();
            return;
        end
        if (part.size() == 0 && v > 8'd7) begin
            exp_ferr++;
            return;
        end
        part.push_back(v);
        if (part.size() == 3) begin
            c.op = part[0][2:0];
            c.a  = part[1];
            c.b  = part[2];
            if (hold_mode && held) exp_ovr++;
            else begin
                exp_q.push_back(c);
                if (hold_mode) held = 1;
            end
            part.delete();
        end
    endfunction

    function automatic void model_timeout();
        if (part.size() != 0) exp_ferr++;
        part.delete();
    endfunction

    task automatic hold(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int nbits, input bit stop_good,
                             input int gap_bits);
        @(posedge clock);
        #1;
        rx = 1'b0;
        last_start = cyc;
        hold(Cpb);
        for (int i = 0; i < nbits; i++) begin
            rx = v[i];
            hold(Cpb);
        end
        if (nbits == 8) begin
            rx = stop_good;
            model_byte(v, stop_good);
            hold(Cpb);
        end
        rx = 1'b1;
        // A low stop bit looks like a new start edge; give the false start room to die out.
        hold(Cpb * (gap_bits + (stop_good ? 0 : 1)));
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_bits);
        send_bits(v, 8, 1'b1, gap_bits);
    endtask

    task automatic rand_frame();
        logic [7:0] b0;
        b0 = {5'd0, 3'($urandom_range(0, 7))};
        if ($urandom_range(0, 7) == 0) b0 = 8'($urandom_range(8, 255));
        send_bits(b0, 8, $urandom_range(0, 11) != 0, $urandom_range(0, 3));
        send_bits(8'($urandom), 8, $urandom_range(0, 11) != 0, $urandom_range(0, 3));
        send_bits(8'($urandom), 8, $urandom_range(0, 11) != 0, $urandom_range(0, 5));
    endtask

    task automatic settle(input string tag);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || cmd.cmd_valid) && n < 2000) begin
            @(posedge clock);
            n++;
        end
        hold(4);
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_ferr_count"}, seen_ferr, exp_ferr);
        check({tag, "_ovr_count"}, seen_ovr, exp_ovr);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clock);
        check({tag, "_valid"}, 32'(cmd.cmd_valid), 32'd0);
        check({tag, "_cmd"}, 32'({cmd.opcode, cmd.a, cmd.b}), 32'd0);
        check({tag, "_pulses"}, 32'({frame_err, overrun}), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        part.delete();
        exp_q.delete();
        held = 0;
        hold(3);
        reset = 1'b0;
    endtask

    // Monitor: scoreboard pops, hold stability, start-to-valid latency, pulse counting.
    initial begin
        cmd_t cur, prev_cmd, e;
        bit   prev_hold, prev_valid;
        int unsigned lat;
        prev_hold  = 0;
        prev_valid = 0;
        forever begin
            @(negedge clock);
            cur = '{op: cmd.opcode, a: cmd.a, b: cmd.b};
            if (reset) begin
                prev_hold  = 0;
                prev_valid = 0;
            end else begin
                if (frame_err) begin
                    seen_ferr++;
                    if (exp_to_at >= 0) begin
                        lat = cyc - 32'(exp_to_at);
                        check("timeout_time_ok", 32'(lat >= 665 && lat <= 669), 32'd1);
                        exp_to_at = -1;
                    end
                end
                if (overrun) seen_ovr++;
                if (prev_hold) check("hold_stable", 32'({cmd.cmd_valid, cur}),
                                     32'({1'b1, prev_cmd}));
                if (cmd.cmd_valid && !prev_valid) begin
                    lat = cyc - last_start;
                    check("valid_latency_ok", 32'(lat >= 154 && lat <= 156), 32'd1);
                end
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_cmd: got op=%0d a=%0h b=%0h, required none",
                                 cur.op, cur.a, cur.b);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd_fields", 32'(cur), 32'(e));
                    end
                end
                prev_hold  = cmd.cmd_valid && !cmd.cmd_ready;
                prev_valid = cmd.cmd_valid;
                prev_cmd   = cur;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) cmd.cmd_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd.cmd_ready = 1'b1;
        hold(4);
        check_reset_state("reset");
        reset = 1'b0;
        hold(Cpb);

        rand_ready = 0;
        cmd.cmd_ready = 1'b1;
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h0A, 2);
        settle("basic");

        rand_ready = 1;
        for (int f = 0; f < 30; f++) rand_frame();
        hold(Cpb * 40);
        model_timeout();
        settle("random");

        // Held command while a second frame completes.
        rand_ready = 0;
        @(posedge clock);
        #1;
        cmd.cmd_ready = 1'b0;
        hold_mode = 1;
        held = 0;
        send_byte(8'h03, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h01, 1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 1);
        @(negedge clock);
        check("ovr_held_valid", 32'(cmd.cmd_valid), 32'd1);
        check("ovr_held_cmd", 32'({cmd.opcode, cmd.a, cmd.b}), 32'({3'd3, 8'hFF, 8'h01}));
        check("ovr_pulses", seen_ovr, exp_ovr);
        @(posedge clock);
        #1;
        cmd.cmd_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("ovr_valid_drop", 32'(cmd.cmd_valid), 32'd0);
        hold_mode = 0;
        settle("overrun");

        rand_ready = 1;
        send_byte(8'h85, 1);
        send_byte(8'h02, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 2);
        settle("bad_byte0");

        send_byte(8'h01, 0);
        send_byte(8'h07, 0);
        exp_to_at = int'(last_start);
        hold(Cpb * 40);
        model_timeout();
        check("timeout_seen", 32'(exp_to_at), 32'hFFFF_FFFF);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 2);
        settle("timeout");

        send_byte(8'h01, 0);
        send_bits(8'h55, 8, 1'b0, 2);
        @(posedge clock);
        #1;
        rx = 1'b0;
        hold(Cpb / 4);
        rx = 1'b1;
        hold(Cpb * 3);
        settle("stop_glitch");

        send_byte(8'h01, 0);
        send_bits(8'h33, 4, 1'b1, 0);
        do_reset();
        check_reset_state("midreset");
        seen_ferr = exp_ferr;
        seen_ovr  = exp_ovr;
        hold(Cpb * 2);
        send_byte(8'h06, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 2);
        settle("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cmd_rx.md
CMD_RX -- requirements
Module: cmd_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit (even, >= 8).
REQ-002 SHALL provide parameter TIMEOUT_BITS, default 32, meaning the maximum idle gap in bit-times between bytes of one frame.
REQ-003 SHALL provide port clock  input  1  system clock; all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port rx  input  1  asynchronous UART serial in, idle high, 8N1, LSB first.
REQ-006 SHALL provide port cmd_ready  input  1  downstream accepts the command when high with cmd_valid.
REQ-007 SHALL provide port cmd_valid  output  1  command registers hold a complete frame.
REQ-008 SHALL provide port opcode  output  3  ALU opcode of the held command.
REQ-009 SHALL provide port a  output  8  first ALU operand.
REQ-010 SHALL provide port b  output  8  second ALU operand.
REQ-011 SHALL provide port frame_err  output  1  one-cycle pulse on a discarded byte or frame.
REQ-012 SHALL provide port overrun  output  1  one-cycle pulse when a complete frame is dropped because cmd_valid is still pending.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer; all decoding uses the synchronized signal.
REQ-014 SHALL implement the bit receiver states IDLE, START, DATA and STOP.
REQ-015 SHALL move from IDLE to START on a synchronized low.
REQ-016 SHALL, in START, resample at CLKS_PER_BIT/2 and go to DATA if the line is low, else return to IDLE with no error.
REQ-017 SHALL, in DATA, sample 8 bits at mid-bit, CLKS_PER_BIT apart, LSB first.
REQ-018 SHALL, in STOP, sample the stop bit at mid-bit and return to IDLE in the same cycle, giving half a bit of slack for back-to-back bytes.
REQ-019 SHALL treat a low stop bit as a framing error: byte discarded, frame_err pulsed, assembler returned to WAIT_OP.
REQ-020 SHALL implement the frame assembler states WAIT_OP, WAIT_A and WAIT_B; a frame is byte0 = {5'b00000, opcode}, byte1 = a, byte2 = b.
REQ-021 SHALL discard a byte0 whose bits [7:3] are nonzero, pulse frame_err and stay in WAIT_OP.
REQ-022 SHALL, in WAIT_A or WAIT_B, discard the partial frame, pulse frame_err and go to WAIT_OP if TIMEOUT_BITS*CLKS_PER_BIT cycles pass with the receiver in IDLE.
REQ-023 SHALL, on the good stop-bit sample of byte2 in cycle N, load opcode/a/b and assert cmd_valid in cycle N+1 if cmd_valid was low or was being accepted in cycle N.
REQ-024 SHALL otherwise drop the completed frame, pulse overrun in N+1 and keep the held command unchanged.
REQ-025 SHALL hold cmd_valid and opcode/a/b stable until a cycle with cmd_valid & cmd_ready, then deassert cmd_valid next cycle unless REQ-023 reloads it.
REQ-026 SHALL keep receiving and assembling bytes while cmd_valid is pending.
REQ-027 SHALL never pulse frame_err and overrun for the same byte.

Reset
REQ-028 SHALL, while reset is high at a clock edge, set: cmd_valid=0, opcode=0, a=0, b=0, frame_err=0, overrun=0, receiver=IDLE, assembler=WAIT_OP, synchronizer flops=1, counters=0.
REQ-029 SHALL discard any byte or frame in progress when reset asserts mid-operation; no command is produced from pre-reset bits.
REQ-030 SHALL require a fresh start bit after reset release before receiving.

Verification (CLKS_PER_BIT=16)
REQ-031 SHALL verify: bytes 0x00,0x05,0x0A sent, cmd_ready=1 -> one cmd_valid pulse with opcode=0, a=5, b=10, one cycle after the byte2 stop sample.
REQ-032 SHALL verify: frame 0x03,0xFF,0x01 with cmd_ready=0, then frame 0x01,0x02,0x03 -> first command held (opcode=3, a=0xFF, b=0x01), overrun pulses once; after cmd_ready=1, cmd_valid drops.
REQ-033 SHALL verify: byte 0x85 as byte0 -> frame_err pulse; following 0x02,0x10,0x20 -> opcode=2, a=0x10, b=0x20.
REQ-034 SHALL verify: 0x01,0x07 then 40 bit-times idle -> frame_err at the 32-bit-time mark; next 0x04,0x01,0x02 decodes correctly.
REQ-035 SHALL verify: byte1 with stop bit forced low -> frame_err, no cmd_valid; a 0.25-bit low glitch on idle rx -> no byte, no error.
REQ-036 SHALL verify: reset pulsed mid-byte1, then 0x06,0x33,0x44 -> opcode=6, a=0x33, b=0x44, no stale command.
